// File: rtl/op_sequencer.sv
// op_sequencer
//
// Front-end controller for a small arithmetic datapath (ADD, MUL2, DIV2).
// It debounces two raw pushbuttons: one steps the selected operation, and
// the other launches a computation. A launch registers the switch operands
// into the datapath, waits one settle cycle, and then captures the datapath
// result and carry. The captured values are held for the display and LEDs.
//
// Ports:
//   MAX10_CLK1_50   system clock, rising edge
//   reset_n         asynchronous active-low reset
//   op_btn_n        raw active-low button, steps the operation
//   go_btn_n        raw active-low button, starts a computation
//   x_in, y_in      switch operands
//   dp_result       combinational datapath result
//   dp_carry        datapath carry / shifted-out bit
//   op_sel          operation select to datapath (0=ADD, 1=MUL2, 2=DIV2)
//   a_out, b_out    registered operands to datapath
//   result, carry   captured datapath outputs
//   busy            high while a computation is in flight
//   done            one-cycle pulse when result/carry update
//   op_led          one-hot operation indicator
module op_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             MAX10_CLK1_50,
  input  logic             reset_n,
  input  logic             op_btn_n,
  input  logic             go_btn_n,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] dp_result,
  input  logic             dp_carry,
  output logic [1:0]       op_sel,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output logic [2:0]       op_led
);

  // The counter only has to reach DEBOUNCE_CYCLES-1. A one-cycle debounce
  // still needs a 1-bit counter so that the vector widths stay legal.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, CAPTURE} state_t;

  // Index 0 is the operation button. Index 1 is the go button.
  logic [1:0]    btn_raw;
  logic [1:0]    btn_meta;
  logic [1:0]    btn_sync;
  logic [1:0]    btn_deb;
  logic [1:0]    btn_press;
  logic [CW-1:0] deb_cnt [2];

  state_t        state;
  state_t        state_next;
  logic [1:0]    op_sel_next;
  logic          load_en;
  logic          capture_en;

  assign btn_raw = {go_btn_n, op_btn_n};

  // Each button passes through the same path: a 2-FF synchronizer, then a
  // stability counter. The counter runs only while the synchronized level
  // disagrees with the accepted level. A press pulse fires on the cycle
  // that the accepted level falls to 0.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta  <= 2'b11;
      btn_sync  <= 2'b11;
      btn_deb   <= 2'b11;
      btn_press <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      for (int i = 0; i < 2; i++) begin
        btn_press[i] <= 1'b0;
        if (btn_sync[i] == btn_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          btn_deb[i]   <= btn_sync[i];
          deb_cnt[i]   <= '0;
          btn_press[i] <= ~btn_sync[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and control logic. Button events are honoured only in IDLE,
  // so an event that arrives while busy is dropped and not queued. If both
  // events arrive together, go takes priority and the op step is lost.
  always_comb begin
    state_next  = state;
    op_sel_next = op_sel;
    load_en     = 1'b0;
    capture_en  = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (btn_press[1])      state_next  = LOAD;
        else if (btn_press[0]) op_sel_next = (op_sel == 2'd2) ? 2'd0 : op_sel + 2'd1;
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = SETTLE;
      end
      SETTLE:  state_next = CAPTURE;
      CAPTURE: begin
        capture_en = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Operation select, operand and capture registers. The controller does no
  // arithmetic itself. It latches whatever the datapath reports.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      op_sel <= 2'd0;
      a_out  <= '0;
      b_out  <= '0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      op_sel <= op_sel_next;
      if (load_en) begin
        a_out <= x_in;
        b_out <= y_in;
      end
      if (capture_en) begin
        result <= dp_result;
        carry  <= dp_carry;
      end
    end
  end

  always_comb begin
    op_led = 3'b001;
    case (op_sel)
      2'd1:    op_led = 3'b010;
      2'd2:    op_led = 3'b100;
      default: op_led = 3'b001;
    endcase
  end

endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer
//
// Directed testbench for op_sequencer. The main instance uses a 4-cycle
// debounce. A second instance uses a 1-cycle debounce: only with that
// setting can two distinct go presses land close enough together for the
// second one to arrive while the first computation is still in flight.
// A behavioural datapath model feeds each instance from its registered
// operands.
module tb_op_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       op_btn_n, go_btn_n;
  logic [3:0] x_in, y_in;
  logic [3:0] dp_result, a_out, b_out, result;
  logic       dp_carry, carry, busy, done;
  logic [1:0] op_sel;
  logic [2:0] op_led;

  logic       f_op_btn_n, f_go_btn_n;
  logic [3:0] f_dp_result, f_a_out, f_b_out, f_result;
  logic       f_dp_carry, f_carry, f_busy, f_done;
  logic [1:0] f_op_sel;
  logic [2:0] f_op_led;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural datapath model, returning {carry, result}.
  function automatic logic [4:0] dp_model(input logic [1:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
    logic [4:0] r;
    r = '0;
    case (op)
      2'd0:    r = {1'b0, a} + {1'b0, b};
      2'd1:    r = {a, 1'b0};
      2'd2:    r = {a[0], 1'b0, a[3:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {dp_carry, dp_result}     = dp_model(op_sel, a_out, b_out);
  assign {f_dp_carry, f_dp_result} = dp_model(f_op_sel, f_a_out, f_b_out);

  op_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .MAX10_CLK1_50(clk), .reset_n(reset_n), .op_btn_n(op_btn_n), .go_btn_n(go_btn_n),
    .x_in(x_in), .y_in(y_in), .dp_result(dp_result), .dp_carry(dp_carry),
    .op_sel(op_sel), .a_out(a_out), .b_out(b_out), .result(result), .carry(carry),
    .busy(busy), .done(done), .op_led(op_led)
  );

  op_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(1)) dut_fast (
    .MAX10_CLK1_50(clk), .reset_n(reset_n), .op_btn_n(f_op_btn_n), .go_btn_n(f_go_btn_n),
    .x_in(x_in), .y_in(y_in), .dp_result(f_dp_result), .dp_carry(f_dp_carry),
    .op_sel(f_op_sel), .a_out(f_a_out), .b_out(f_b_out), .result(f_result), .carry(f_carry),
    .busy(f_busy), .done(f_done), .op_led(f_op_led)
  );

  // Hold the op button low for 'hold' cycles inside a 'window'-cycle span.
  // Count op_sel changes and note the cycle of the first change.
  task automatic run_op(input int hold, input int window, output int changes,
                        output int first_change);
    logic [1:0] prev;
    prev = op_sel;
    changes = 0;
    first_change = -1;
    for (int i = 0; i < window; i++) begin
      op_btn_n = (i < hold) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (op_sel !== prev) begin
        changes++;
        if (first_change < 0) first_change = i + 1;
        prev = op_sel;
      end
    end
    op_btn_n = 1'b1;
  endtask

  // Hold go low for 10 cycles. If with_op is set, also hold op low for
  // 10 cycles, starting op_off cycles later. Observe for 40 cycles.
  task automatic run_go(input int op_off, input bit with_op, output int busy_n,
                        output int done_n, output int first_busy, output int done_at,
                        output int op_changes);
    logic [1:0] prev;
    prev = op_sel;
    busy_n = 0; done_n = 0; first_busy = -1; done_at = -1; op_changes = 0;
    for (int i = 0; i < 40; i++) begin
      go_btn_n = (i < 10) ? 1'b0 : 1'b1;
      op_btn_n = (with_op && i >= op_off && i < op_off + 10) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_n++;
        if (first_busy < 0) first_busy = i + 1;
      end
      if (done === 1'b1) begin
        done_n++;
        done_at = i + 1;
      end
      if (op_sel !== prev) begin
        op_changes++;
        prev = op_sel;
      end
    end
    go_btn_n = 1'b1;
    op_btn_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    op_btn_n = 1'b1; go_btn_n = 1'b1; f_op_btn_n = 1'b1; f_go_btn_n = 1'b1;
    x_in = 4'd0; y_in = 4'd0;
    repeat (3) @(negedge clk);
    total++; if (op_sel !== 2'd0)    begin bad++; $display("[TB] FAIL reset_op_sel: got %0d expected 0", op_sel); end
    total++; if (op_led !== 3'b001)  begin bad++; $display("[TB] FAIL reset_op_led: got %b expected 001", op_led); end
    total++; if (result !== 4'd0)    begin bad++; $display("[TB] FAIL reset_result: got %0d expected 0", result); end
    total++; if (carry !== 1'b0)     begin bad++; $display("[TB] FAIL reset_carry: got %b expected 0", carry); end
    total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    total++; if (a_out !== 4'd0)     begin bad++; $display("[TB] FAIL reset_a_out: got %0d expected 0", a_out); end
    total++; if (b_out !== 4'd0)     begin bad++; $display("[TB] FAIL reset_b_out: got %0d expected 0", b_out); end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({op_sel, op_led, result, carry, busy, done} !== {2'd0, 3'b001, 4'd0, 3'b000}) begin
        bad++;
        $display("[TB] FAIL post_reset_idle cycle %0d: got op_sel=%0d op_led=%b result=%0d carry=%b busy=%b done=%b expected 0/001/0/0/0/0",
                 i, op_sel, op_led, result, carry, busy, done);
      end
    end
  endtask

  task automatic test_op_step();
    logic [1:0] exp_sel [3];
    logic [2:0] exp_led [3];
    int ch, fc;
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd0;
    exp_led[0] = 3'b010; exp_led[1] = 3'b100; exp_led[2] = 3'b001;
    for (int k = 0; k < 3; k++) begin
      run_op(10, 25, ch, fc);
      total++; if (ch !== 1) begin bad++; $display("[TB] FAIL step%0d_changes: got %0d expected 1", k, ch); end
      total++; if (fc < 1 || fc > 7) begin bad++; $display("[TB] FAIL step%0d_latency: got %0d expected 1..7", k, fc); end
      total++; if (op_sel !== exp_sel[k]) begin bad++; $display("[TB] FAIL step%0d_op_sel: got %0d expected %0d", k, op_sel, exp_sel[k]); end
      total++; if (op_led !== exp_led[k]) begin bad++; $display("[TB] FAIL step%0d_op_led: got %b expected %b", k, op_led, exp_led[k]); end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] start;
    int ch, fc;
    start = op_sel;
    ch = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 3; i++) begin
        op_btn_n = (i < 2) ? 1'b0 : 1'b1;
        @(negedge clk);
        if (op_sel !== start) ch++;
      end
    end
    op_btn_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (op_sel !== start) ch++;
    end
    total++; if (ch !== 0) begin bad++; $display("[TB] FAIL bounce_changes: got %0d expected 0", ch); end
    total++; if (op_sel !== 2'd0) begin bad++; $display("[TB] FAIL bounce_op_sel: got %0d expected 0", op_sel); end
    run_op(10, 25, ch, fc);
    total++; if (ch !== 1) begin bad++; $display("[TB] FAIL hold_after_bounce_changes: got %0d expected 1", ch); end
    total++; if (op_sel !== 2'd1) begin bad++; $display("[TB] FAIL hold_after_bounce_op_sel: got %0d expected 1", op_sel); end
  endtask

  task automatic test_div2();
    int ch, fc, bn, dn, fb, da, oc;
    run_op(10, 25, ch, fc);
    total++; if (op_sel !== 2'd2) begin bad++; $display("[TB] FAIL div2_select: got %0d expected 2", op_sel); end
    x_in = 4'd7; y_in = 4'd5;
    run_go(0, 1'b0, bn, dn, fb, da, oc);
    total++; if (bn !== 3) begin bad++; $display("[TB] FAIL div2_busy_cycles: got %0d expected 3", bn); end
    total++; if (dn !== 1) begin bad++; $display("[TB] FAIL div2_done_pulses: got %0d expected 1", dn); end
    total++; if (fb < 1 || fb > 7) begin bad++; $display("[TB] FAIL div2_busy_start: got %0d expected 1..7", fb); end
    total++; if (da !== fb + 2) begin bad++; $display("[TB] FAIL div2_done_timing: got %0d expected %0d", da, fb + 2); end
    total++; if (result !== 4'd3) begin bad++; $display("[TB] FAIL div2_result: got %0d expected 3", result); end
    total++; if (carry !== 1'b1) begin bad++; $display("[TB] FAIL div2_carry: got %b expected 1", carry); end
    total++; if (a_out !== 4'd7) begin bad++; $display("[TB] FAIL div2_a_out: got %0d expected 7", a_out); end
    x_in = 4'd15;
    repeat (10) @(negedge clk);
    total++; if (result !== 4'd3) begin bad++; $display("[TB] FAIL div2_hold_result: got %0d expected 3", result); end
    total++; if (carry !== 1'b1) begin bad++; $display("[TB] FAIL div2_hold_carry: got %b expected 1", carry); end
  endtask

  task automatic test_add();
    int ch, fc, bn, dn, fb, da, oc;
    run_op(10, 25, ch, fc);
    total++; if (op_sel !== 2'd0) begin bad++; $display("[TB] FAIL add_select: got %0d expected 0", op_sel); end
    x_in = 4'd9; y_in = 4'd8;
    run_go(0, 1'b0, bn, dn, fb, da, oc);
    total++; if (bn !== 3) begin bad++; $display("[TB] FAIL add_busy_cycles: got %0d expected 3", bn); end
    total++; if (dn !== 1) begin bad++; $display("[TB] FAIL add_done_pulses: got %0d expected 1", dn); end
    total++; if (da !== fb + 2) begin bad++; $display("[TB] FAIL add_done_timing: got %0d expected %0d", da, fb + 2); end
    total++; if (result !== 4'd1) begin bad++; $display("[TB] FAIL add_result: got %0d expected 1", result); end
    total++; if (carry !== 1'b1) begin bad++; $display("[TB] FAIL add_carry: got %b expected 1", carry); end
    total++; if (b_out !== 4'd8) begin bad++; $display("[TB] FAIL add_b_out: got %0d expected 8", b_out); end
  endtask

  task automatic test_back_to_back();
    int bn, dn, fb, da, oc;
    int fdone, fbusy;
    bit seen;
    // An op press one cycle behind go lands while the FSM is in LOAD.
    x_in = 4'd5; y_in = 4'd6;
    run_go(1, 1'b1, bn, dn, fb, da, oc);
    total++; if (oc !== 0) begin bad++; $display("[TB] FAIL op_in_load_changes: got %0d expected 0", oc); end
    total++; if (dn !== 1) begin bad++; $display("[TB] FAIL op_in_load_done: got %0d expected 1", dn); end
    total++; if (result !== 4'd11) begin bad++; $display("[TB] FAIL op_in_load_result: got %0d expected 11", result); end
    // Simultaneous op and go presses: go wins.
    x_in = 4'd2; y_in = 4'd3;
    run_go(0, 1'b1, bn, dn, fb, da, oc);
    total++; if (oc !== 0) begin bad++; $display("[TB] FAIL simul_op_changes: got %0d expected 0", oc); end
    total++; if (dn !== 1) begin bad++; $display("[TB] FAIL simul_done: got %0d expected 1", dn); end
    total++; if (result !== 4'd5) begin bad++; $display("[TB] FAIL simul_result: got %0d expected 5", result); end
    total++; if (carry !== 1'b0) begin bad++; $display("[TB] FAIL simul_carry: got %b expected 0", carry); end
    // On the fast instance, a second go press lands in SETTLE.
    x_in = 4'd3; y_in = 4'd4;
    fdone = 0; fbusy = 0;
    for (int i = 0; i < 25; i++) begin
      f_go_btn_n = (i == 0 || (i >= 2 && i <= 4)) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (f_done === 1'b1) fdone++;
      if (f_busy === 1'b1) fbusy++;
    end
    f_go_btn_n = 1'b1;
    total++; if (fdone !== 1) begin bad++; $display("[TB] FAIL go_in_settle_done: got %0d expected 1", fdone); end
    total++; if (fbusy !== 3) begin bad++; $display("[TB] FAIL go_in_settle_busy: got %0d expected 3", fbusy); end
    total++; if (f_result !== 4'd7) begin bad++; $display("[TB] FAIL go_in_settle_result: got %0d expected 7", f_result); end
    total++; if (f_carry !== 1'b0) begin bad++; $display("[TB] FAIL go_in_settle_carry: got %b expected 0", f_carry); end
    total++; if ({f_a_out, f_b_out} !== {4'd3, 4'd4}) begin bad++; $display("[TB] FAIL go_in_settle_operands: got %0d,%0d expected 3,4", f_a_out, f_b_out); end
    total++; if ({f_op_sel, f_op_led} !== {2'd0, 3'b001}) begin bad++; $display("[TB] FAIL go_in_settle_op: got %0d/%b expected 0/001", f_op_sel, f_op_led); end
    // Assert reset while the main instance sits in SETTLE.
    x_in = 4'd9; y_in = 4'd8;
    seen = 1'b0;
    go_btn_n = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL reset_settle_wait: got busy=%b expected 1 within 20 cycles", busy); end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    go_btn_n = 1'b1;
    #1;
    total++; if (result !== 4'd0) begin bad++; $display("[TB] FAIL reset_settle_result: got %0d expected 0", result); end
    total++; if (carry !== 1'b0) begin bad++; $display("[TB] FAIL reset_settle_carry: got %b expected 0", carry); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_settle_busy: got %b expected 0", busy); end
    fdone = 0; fbusy = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) reset_n = 1'b1;
      @(negedge clk);
      if (done === 1'b1) fdone++;
      if (busy === 1'b1) fbusy++;
    end
    total++; if (fdone !== 0) begin bad++; $display("[TB] FAIL reset_settle_done: got %0d expected 0", fdone); end
    total++; if (fbusy !== 0) begin bad++; $display("[TB] FAIL reset_settle_idle: got %0d busy cycles expected 0", fbusy); end
    total++; if (result !== 4'd0) begin bad++; $display("[TB] FAIL reset_settle_hold: got %0d expected 0", result); end
  endtask

  initial begin
    test_reset();
    test_op_step();
    test_bounce();
    test_div2();
    test_add();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
- Front-end controller for the 4-bit arithmetic datapath: adder, multiply-by-2 and divide-by-2 units.
- Debounces two raw pushbuttons.
  - One button steps through the selected operation.
  - The other launches a computation.
- Registers the switch operands into the datapath, then captures the datapath result and carry after a fixed settle cycle.
- Holds result and carry stable for the seven-segment decoder and the LEDs.

Parameters:
- WIDTH, 4, operand/result width in bits.
- DEBOUNCE_CYCLES, 500000, consecutive stable clock cycles required to accept a button level (10 ms at 50 MHz).

Ports:
- MAX10_CLK1_50  input  1  system clock, 50 MHz; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op_btn_n  input  1  raw pushbutton, active-low, asynchronous; steps the operation.
- go_btn_n  input  1  raw pushbutton, active-low, asynchronous; starts a computation.
- x_in  input  WIDTH  operand X from switches.
- y_in  input  WIDTH  operand Y from switches.
- dp_result  input  WIDTH  combinational datapath result.
- dp_carry  input  1  datapath carry / shifted-out bit.
- op_sel  output  2  operation to datapath mux: 0=ADD, 1=MUL2, 2=DIV2.
- a_out  output  WIDTH  registered operand A to datapath.
- b_out  output  WIDTH  registered operand B to datapath.
- result  output  WIDTH  captured result, to seven-segment decoder.
- carry  output  1  captured carry.
- busy  output  1  high while a computation is in flight.
- done  output  1  one-cycle pulse when result/carry update.
- op_led  output  3  one-hot operation indicator: 001=ADD, 010=MUL2, 100=DIV2.

Behaviour:
- Reset (reset_n low, takes effect asynchronously):
  - state=IDLE, op_sel=0, op_led=001.
  - a_out, b_out, result = 0; carry, busy, done = 0.
  - Debounce counters = 0; debounced button levels = 1 (released).
- Button input path, identical for each button:
  - 2-FF synchronizer.
  - Debounce: the counter increments while the synchronized level differs from the debounced level, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1 the debounced level is updated and the counter clears.
  - A press event is a one-cycle pulse on a debounced 1->0 transition; releases produce no event.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- FSM states: IDLE, LOAD, SETTLE, CAPTURE.
  - IDLE, busy=0:
    - go event -> LOAD.
    - Otherwise, op event -> op_sel increments 0->1->2->0; value 3 is never produced. op_led tracks op_sel in the same cycle.
  - LOAD, busy=1: a_out<=x_in, b_out<=y_in; -> SETTLE.
  - SETTLE, busy=1: no register updates; datapath settles on the registered operands; -> CAPTURE.
  - CAPTURE, busy=1: result<=dp_result, carry<=dp_carry, done=1 for this cycle only; -> IDLE.
- Latency: a go event sampled in IDLE at cycle n gives busy=1 on n+1..n+3, done=1 at n+3, and result valid from n+4.
- op_sel is frozen from LOAD through CAPTURE.
- op and go events arriving while busy=1 are dropped, not queued.
- Simultaneous op and go events in IDLE: go wins, the op event is dropped, and the computation uses the current op_sel.
- result and carry hold their last captured values indefinitely; switch changes have no effect until the next go.
- Reset asserted in any state aborts the computation immediately to the reset values. No done pulse is issued and no partial capture occurs.
- The controller performs no arithmetic. Carry semantics belong to the datapath (ADD carry-out, MUL2 MSB shifted out, DIV2 LSB shifted out) and are captured unchanged.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4 and a behavioural datapath model.)
- Reset check: hold reset_n=0 with buttons released -> op_sel=0, op_led=001, result=0, carry=0, busy=0, done=0. Release reset -> all outputs unchanged for 20 cycles.
- Operation stepping: three clean op presses, each held low 10 cycles -> op_sel 1, 2, 0 and op_led 010, 100, 001. Each change occurs exactly once per press, within 2+4+1 cycles of the falling edge.
- Bounce rejection: op_btn_n pulses low for 2 cycles, 3 times, each separated by 1 high cycle -> no op event, op_sel unchanged. A 10-cycle low hold afterwards -> exactly one increment.
- ADD computation: op_sel=0, x_in=9, y_in=8, press go -> busy=1 for 3 cycles, single done pulse, result=1, carry=1.
- DIV2 computation: op_sel=2, x_in=7, press go -> result=3, carry=1. Changing x_in to 15 afterwards leaves result=3.
- Busy and reset interactions:
  - go event during SETTLE -> ignored, exactly one done pulse.
  - op event during LOAD -> op_sel unchanged.
  - reset_n asserted during SETTLE -> result=0, no done pulse, FSM returns to IDLE.
